ad9866_spi_sequencer: RTL and testbench

// - Owns the AD9866 control port (reset pin plus 3-wire SPI). After reset it pulses ad9866_rst_n
//   and writes a fixed init table to the codec.
// - It then arbitrates two write requesters and serialises their frames:
//   - host register writes decoded from the Ethernet command stream;
//   - RX PGA gain updates.
// - Sits in the core between the command decoder and the ad9866_sclk/sdio/sen_n/rst_n pins.

---
 rtl/ad9866_spi_sequencer_if.sv | 12 +
 rtl/ad9866_spi_sequencer.sv | 140 ++++++++++++++
 tb/tb_ad9866_spi_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad9866_spi_sequencer_if.sv
// ad9866_spi_sequencer_if: host and gain write-request handshakes into the AD9866 SPI sequencer
interface ad9866_spi_sequencer_if;
   logic       cmd_req;
   logic [5:0] cmd_addr;
   logic [7:0] cmd_data;
   logic       cmd_ack;
   logic       gain_req;
   logic [5:0] gain_val;
   logic       gain_ack;
   modport master (output cmd_req, cmd_addr, cmd_data, gain_req, gain_val, input cmd_ack, gain_ack);
   modport slave  (input cmd_req, cmd_addr, cmd_data, gain_req, gain_val, output cmd_ack, gain_ack);
endinterface

// File: rtl/ad9866_spi_sequencer.sv
// ad9866_spi_sequencer: pulses the AD9866 reset pin, writes the init table, then serialises
// host and RX gain register writes (round-robin) onto the 3-wire SPI port.
module ad9866_spi_sequencer #(
   parameter int SCLK_DIV = 4,
   parameter int RST_CYCLES = 1024,
   parameter int WAIT_CYCLES = 4096,
   parameter int GAP_CYCLES = 8,
   parameter int INIT_N = 4,
   parameter logic [14*INIT_N-1:0] INIT_TABLE = '0,
   parameter logic [5:0] GAIN_ADDR = 6'h09
) (
   input  logic ad9866spiclk,
   input  logic rst_n,
   ad9866_spi_sequencer_if.slave bus,
   output logic init_done,
   output logic busy,
   output logic ad9866_rst_n,
   output logic ad9866_sclk,
   output logic ad9866_sdio,
   output logic ad9866_sen_n
);
   localparam int M1 = RST_CYCLES > WAIT_CYCLES ? RST_CYCLES : WAIT_CYCLES;
   localparam int M2 = GAP_CYCLES > 2*SCLK_DIV ? GAP_CYCLES : 2*SCLK_DIV;
   localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);
   localparam logic [CW-1:0] RST_END = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] WAIT_END = CW'(WAIT_CYCLES - 1);
   localparam logic [CW-1:0] GAP_END = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] HALF = CW'(SCLK_DIV);
   localparam logic [CW-1:0] HALF_END = CW'(SCLK_DIV - 1);
   localparam logic [CW-1:0] BIT_END = CW'(2*SCLK_DIV - 1);
   localparam logic [3:0] LAST_IDX = 4'(INIT_N - 1);

   typedef enum logic [2:0] {RST_HOLD, RST_WAIT, LOAD, SHIFT, GAP, IDLE} state_t;
   typedef enum logic [1:0] {SRC_INIT, SRC_CMD, SRC_GAIN} src_t;

   state_t state, state_n;
   src_t src, src_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [4:0] bn, bn_n;
   logic [15:0] sr, sr_n, frame;
   logic [3:0] idx, idx_n;
   logic last_gain, last_gain_n, done_n, live;

   always_ff @(posedge ad9866spiclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RST_HOLD;
         src <= SRC_INIT;
         cnt <= '0;
         bn <= '0;
         sr <= '0;
         idx <= '0;
         last_gain <= 1'b0;
         init_done <= 1'b0;
      end else begin
         state <= state_n;
         src <= src_n;
         cnt <= cnt_n;
         bn <= bn_n;
         sr <= sr_n;
         idx <= idx_n;
         last_gain <= last_gain_n;
         init_done <= done_n;
      end
   end

   // A host/gain request that was dropped between arbitration and LOAD is not "live": no frame, no ack.
   always_comb begin
      live = src == SRC_INIT || (src == SRC_CMD && bus.cmd_req) || (src == SRC_GAIN && bus.gain_req);
      frame = src == SRC_INIT ? {2'b00, INIT_TABLE[14*idx +: 14]} :
              src == SRC_CMD  ? {2'b00, bus.cmd_addr, bus.cmd_data} :
                                {2'b00, GAIN_ADDR, 2'b01, bus.gain_val};
   end

   always_comb begin
      state_n = state;
      src_n = src;
      cnt_n = cnt + 1'b1;
      bn_n = bn;
      sr_n = sr;
      idx_n = idx;
      last_gain_n = last_gain;
      done_n = init_done;
      case (state)
         RST_HOLD: if (cnt == RST_END) begin
            state_n = RST_WAIT;
            cnt_n = '0;
         end
         RST_WAIT: if (cnt == WAIT_END) begin
            state_n = LOAD;
            cnt_n = '0;
            src_n = SRC_INIT;
            idx_n = '0;
         end
         LOAD: begin
            cnt_n = '0;
            bn_n = '0;
            sr_n = frame;
            state_n = live ? SHIFT : IDLE;
            last_gain_n = (live && src != SRC_INIT) ? src == SRC_GAIN : last_gain;
         end
         // bn 0..15 are data bits; bn 16 is the trailing low half-period before GAP
         SHIFT: if (bn == 5'd16) begin
            if (cnt == HALF_END) begin
               state_n = GAP;
               cnt_n = '0;
            end
         end else if (cnt == BIT_END) begin
            cnt_n = '0;
            bn_n = bn + 1'b1;
            sr_n = {sr[14:0], 1'b0};
         end
         GAP: if (cnt == GAP_END) begin
            cnt_n = '0;
            if (src == SRC_INIT && idx != LAST_IDX) begin
               idx_n = idx + 1'b1;
               state_n = LOAD;
            end else begin
               done_n = init_done | (src == SRC_INIT);
               state_n = IDLE;
            end
         end
         IDLE: begin
            cnt_n = '0;
            if (bus.cmd_req || bus.gain_req) begin
               state_n = LOAD;
               src_n = (bus.gain_req && (!bus.cmd_req || !last_gain)) ? SRC_GAIN : SRC_CMD;
            end
         end
         default: state_n = RST_HOLD;
      endcase
   end

   assign bus.cmd_ack = state == LOAD && src == SRC_CMD && bus.cmd_req;
   assign bus.gain_ack = state == LOAD && src == SRC_GAIN && bus.gain_req;
   assign busy = state != IDLE;
   assign ad9866_rst_n = state != RST_HOLD;
   assign ad9866_sen_n = !((state == LOAD && live) || state == SHIFT);
   assign ad9866_sclk = state == SHIFT && bn != 5'd16 && cnt >= HALF;
   assign ad9866_sdio = state == LOAD ? frame[15] & live : state == SHIFT ? sr[15] : 1'b0;
endmodule

// File: tb/tb_ad9866_spi_sequencer.sv
// tb_ad9866_spi_sequencer: table-driven requests plus arbitration/reset sequences; an SPI
// monitor decodes every frame and compares it against a queue of expected frames.
module tb_ad9866_spi_sequencer;
   logic clk, rst_n;
   logic init_done, busy, ad9866_rst_n, ad9866_sclk, ad9866_sdio, ad9866_sen_n;
   ad9866_spi_sequencer_if bus();

   ad9866_spi_sequencer #(
      .SCLK_DIV(2), .RST_CYCLES(10), .WAIT_CYCLES(20), .GAP_CYCLES(8), .INIT_N(2),
      .INIT_TABLE({14'h0A55, 14'h0133}), .GAIN_ADDR(6'h09)
   ) dut (
      .ad9866spiclk(clk), .rst_n(rst_n), .bus(bus), .init_done(init_done), .busy(busy),
      .ad9866_rst_n(ad9866_rst_n), .ad9866_sclk(ad9866_sclk), .ad9866_sdio(ad9866_sdio),
      .ad9866_sen_n(ad9866_sen_n)
   );

   typedef struct {
      logic g;
      logic [5:0] a;
      logic [7:0] d;
      logic b2b;
      logic [15:0] exp;
   } vec_t;

   vec_t tv[9];
   logic [15:0] exp_q[$];
   int tests = 0, fails = 0, frames = 0;
   int m_rises, m_low, m_gap, m_bad;
   logic m_in = 0, m_have = 0, p_sclk = 0, p_sdio = 0;
   logic [15:0] m_sh, e;

   initial clk = 0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   // SPI monitor: captures sdio on sclk rises, checks frame contents, length, edges and gaps
   always @(negedge clk) begin
      if (!rst_n) begin
         m_in = 0;
         m_have = 0;
      end else if (!ad9866_sen_n) begin
         if (!m_in) begin
            if (m_have) chk($sformatf("gap%0d", frames), m_gap >= 8, 1);
            m_in = 1;
            m_sh = 0;
            m_rises = 0;
            m_low = 0;
            m_bad = 0;
         end
         m_low++;
         if (ad9866_sclk && !p_sclk) begin
            m_sh = {m_sh[14:0], ad9866_sdio};
            m_rises++;
         end
         if (ad9866_sclk && p_sclk && ad9866_sdio != p_sdio) m_bad++;
      end else begin
         if (m_in) begin
            m_in = 0;
            m_have = 1;
            m_gap = 0;
            if (exp_q.size() == 0) chk($sformatf("unexpected_frame%0d", frames), exp_q.size(), 1);
            else begin
               e = exp_q.pop_front();
               chk($sformatf("frame%0d", frames), m_sh, e);
               chk($sformatf("rises%0d", frames), m_rises, 16);
               chk($sformatf("sen_low%0d", frames), m_low, 67);
               chk($sformatf("sdio_stable%0d", frames), m_bad, 0);
            end
            frames++;
         end
         m_gap++;
      end
      p_sclk = ad9866_sclk;
      p_sdio = ad9866_sdio;
   end

   task automatic wait_ack(input logic g, input string nm, output int n);
      logic seen;
      n = 0;
      seen = 0;
      while (!seen && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
         seen = g ? bus.gain_ack : bus.cmd_ack;
         if (g ? bus.cmd_ack : bus.gain_ack) chk({nm, "_order"}, 1'b1, 1'b0);
      end
      chk({nm, "_ack_seen"}, seen, 1);
   endtask

   task automatic after_ack(input logic g, input string nm);
      @(posedge clk);
      #1;
      chk({nm, "_ack_pulse"}, g ? bus.gain_ack : bus.cmd_ack, 0);
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({nm, "_idle"}, busy, 0);
   endtask

   task automatic hold_count(input string nm);
      int n = 0;
      while (!ad9866_rst_n && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({nm, "_rst_hold"}, n, 10);
   endtask

   initial begin
      int n;
      logic idle;
      tv[0] = '{1'b0, 6'h2A, 8'hC3, 1'b0, 16'h2AC3};
      tv[1] = '{1'b0, 6'h00, 8'h00, 1'b0, 16'h0000};
      tv[2] = '{1'b0, 6'h3F, 8'hFF, 1'b0, 16'h3FFF};
      tv[3] = '{1'b1, 6'h15, 8'h00, 1'b0, 16'h0955};
      tv[4] = '{1'b1, 6'h3F, 8'h00, 1'b0, 16'h097F};
      tv[5] = '{1'b1, 6'h00, 8'h00, 1'b0, 16'h0940};
      tv[6] = '{1'b0, 6'h12, 8'h34, 1'b0, 16'h1234};
      tv[7] = '{1'b0, 6'h21, 8'hA5, 1'b1, 16'h21A5};
      tv[8] = '{1'b0, 6'h05, 8'h0F, 1'b1, 16'h050F};
      rst_n = 0;
      bus.cmd_req = 0;
      bus.cmd_addr = 0;
      bus.cmd_data = 0;
      bus.gain_req = 0;
      bus.gain_val = 0;
      #12;
      chk("rst_pin", ad9866_rst_n, 0);
      chk("rst_sclk", ad9866_sclk, 0);
      chk("rst_sdio", ad9866_sdio, 0);
      chk("rst_sen_n", ad9866_sen_n, 1);
      chk("rst_cmd_ack", bus.cmd_ack, 0);
      chk("rst_gain_ack", bus.gain_ack, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_busy", busy, 1);
      exp_q.push_back(16'h0133);
      exp_q.push_back(16'h0A55);
      exp_q.push_back(16'h3C5A);
      @(negedge clk);
      rst_n = 1;
      hold_count("init");
      // host request raised while the codec is still waiting after reset
      bus.cmd_addr = 6'h3C;
      bus.cmd_data = 8'h5A;
      bus.cmd_req = 1;
      chk("t4_early_no_done", init_done, 0);
      wait_ack(0, "t4", n);
      chk("t4_init_done", init_done, 1);
      after_ack(0, "t4");
      bus.cmd_req = 0;

      for (int i = 0; i < 9; i++) begin
         if (!tv[i].b2b) wait_idle($sformatf("vec%0d", i));
         idle = !busy;
         if (tv[i].g) begin
            bus.gain_val = tv[i].a;
            bus.gain_req = 1;
         end else begin
            bus.cmd_addr = tv[i].a;
            bus.cmd_data = tv[i].d;
            bus.cmd_req = 1;
         end
         exp_q.push_back(tv[i].exp);
         wait_ack(tv[i].g, $sformatf("vec%0d", i), n);
         if (idle) chk($sformatf("vec%0d_latency", i), n, 1);
         after_ack(tv[i].g, $sformatf("vec%0d", i));
         if (i == 8 || !tv[i+1].b2b) begin
            bus.cmd_req = 0;
            bus.gain_req = 0;
         end
      end

      // simultaneous requests; gain re-raised right after its ack forms the second tie
      wait_idle("tie");
      exp_q.push_back(16'h096A);
      exp_q.push_back(16'h33CC);
      exp_q.push_back(16'h0941);
      bus.gain_val = 6'h2A;
      bus.cmd_addr = 6'h33;
      bus.cmd_data = 8'hCC;
      bus.gain_req = 1;
      bus.cmd_req = 1;
      wait_ack(1, "tie1", n);
      chk("tie1_latency", n, 1);
      after_ack(1, "tie1");
      bus.gain_val = 6'h01;
      wait_ack(0, "tie2", n);
      after_ack(0, "tie2");
      bus.cmd_req = 0;
      wait_ack(1, "tie3", n);
      after_ack(1, "tie3");
      bus.gain_req = 0;

      // abort a frame at bit 7 with rst_n, then check the full replay
      wait_idle("t5");
      bus.cmd_addr = 6'h11;
      bus.cmd_data = 8'h22;
      bus.cmd_req = 1;
      wait_ack(0, "t5_abort", n);
      after_ack(0, "t5_abort");
      bus.cmd_req = 0;
      n = 0;
      while (m_rises < 8 && n < 500) begin
         @(negedge clk);
         n++;
      end
      while (ad9866_sclk && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("t5_reach_bit7", m_rises, 8);
      #2;
      rst_n = 0;
      #1;
      chk("t5_sen_n", ad9866_sen_n, 1);
      chk("t5_sclk", ad9866_sclk, 0);
      chk("t5_rst_pin", ad9866_rst_n, 0);
      chk("t5_busy", busy, 1);
      chk("t5_init_done", init_done, 0);
      exp_q.push_back(16'h0133);
      exp_q.push_back(16'h0A55);
      exp_q.push_back(16'h0943);
      exp_q.push_back(16'h0799);
      bus.cmd_addr = 6'h07;
      bus.cmd_data = 8'h99;
      bus.gain_val = 6'h03;
      bus.cmd_req = 1;
      bus.gain_req = 1;
      repeat (3) @(negedge clk);
      rst_n = 1;
      hold_count("t5");
      wait_ack(1, "t5_gain", n);
      chk("t5_done_at_ack", init_done, 1);
      after_ack(1, "t5_gain");
      bus.gain_req = 0;
      wait_ack(0, "t5_cmd", n);
      after_ack(0, "t5_cmd");
      bus.cmd_req = 0;
      wait_idle("end");
      repeat (4) @(posedge clk);
      chk("pending_frames", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
